pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
Program-counter register and instruction-fetch sequencer. It sits directly downstream of the branch-select mux and consumes the selected next address (PC+4 or branch target). It holds the architectural PC and drives the instruction-memory request/acknowledge handshake. It presents the fetched instruction, PC and PC+4 to decode and to the PC+4 / branch-target adders that feed the mux.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
IMEM_TIMEOUT, 16, number of FETCH cycles without acknowledge before a timeout error. Legal range 2..255; the counter is 8 bits.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
nextPc  in  32  next address selected by the branch mux.
pcWrite  in  1  consumer accepts the current instruction; PC advances to nextPc.
imemReq  out  1  instruction-memory request.
imemAddr  out  32  request address; always equals pc.
imemAck  in  1  one-cycle acknowledge; imemRdata valid in the same cycle.
imemRdata  in  32  instruction word.
pc  out  32  current PC.
pcPlus4  out  32  pc + 4, combinational, wraps modulo 2^32.
instr  out  32  latched instruction.
instrValid  out  1  instr is valid for pc.
misalignErr  out  1  sticky: an accepted nextPc had bits [1:0] != 0.
timeoutErr  out  1  sticky: imemAck was not received within IMEM_TIMEOUT cycles.

Behaviour:
- Single clock domain: clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, pc=RESET_PC, instr=0, instrValid=0, imemReq=0, misalignErr=0, timeoutErr=0, timeout counter=0.
- States: IDLE, FETCH, READY, HALT.
- IDLE: entered on reset. Moves unconditionally to FETCH on the first rising edge after rst_n deasserts.
- FETCH: imemReq=1 and imemAddr=pc.
  - imemAck=1: instr<=imemRdata, instrValid<=1, counter<=0, next state READY.
  - imemAck=0: counter increments. If the counter reaches IMEM_TIMEOUT-1 with no ack in that cycle: timeoutErr<=1, next state HALT.
  - pcWrite is ignored in FETCH.
- READY: imemReq=0, instrValid=1, instr held stable.
  - pcWrite=1 and nextPc[1:0]==0: pc<=nextPc, instrValid<=0, next state FETCH.
  - pcWrite=1 and nextPc[1:0]!=0: misalignErr<=1, pc unchanged, instrValid<=0, next state HALT.
  - pcWrite=0: hold (stall). No limit on stall length.
- HALT: imemReq=0 and instrValid=0. pc frozen. Exits only via reset.
- imemAck outside FETCH is ignored; no state or data change.
- Latency:
  - Zero-wait memory: imemReq high one cycle, instrValid high the next cycle.
  - Minimum fetch-to-fetch period: 2 cycles (FETCH with ack, READY with pcWrite).
- nextPc == pc (branch-to-self) is a legal jump. It refetches the same address.
- pc wrap from 32'hFFFF_FFFC: pcPlus4 = 32'h0000_0000, no error.
- Reset asserted mid-FETCH or mid-READY: all outputs return to reset values immediately. A pending ack is discarded.

Optional Feature:
Macro PC_FETCH_PERF_EN.
- Defined: adds outputs retiredCount[31:0] and stallCount[31:0], both reset to 0.
  - retiredCount increments on each accepted, aligned pcWrite in READY.
  - stallCount increments on each READY cycle with pcWrite=0.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: neither port nor counter exists; the rest of the behaviour is identical.

Test Plan:
1. Reset with RESET_PC=0, release; ack zero-wait with imemRdata=32'h00500093 -> imemReq high with imemAddr=0 on cycle 1; instrValid=1 and instr=32'h00500093 on cycle 2.
2. READY, pcWrite=1, nextPc=32'h4; then ack with 32'h00A00113 -> pc=4, imemAddr=4, instr=32'h00A00113. Repeat with branch nextPc=32'h40 -> pc=32'h40.
3. Hold pcWrite=0 for 5 READY cycles -> instr and pc stable, imemReq=0 throughout. With PERF_EN: stallCount=5, retiredCount unchanged.
4. Accept nextPc=32'h0000_0006 -> misalignErr=1, state HALT, pc unchanged. Further acks and pcWrite pulses are ignored until rst_n is pulsed low.
5. IMEM_TIMEOUT=4, never ack -> timeoutErr=1 after the 4th FETCH cycle, imemReq=0 from then on.
6. Assert rst_n low while imemReq=1 and imemAck arrives in the same cycle -> outputs return to reset values, instr=0, instrValid=0. Fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer (IDLE/FETCH/READY/HALT).
// Define PC_FETCH_PERF_EN to add the saturating retiredCount/stallCount outputs.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] nextPc,
  input  logic        pcWrite,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic [31:0] instr,
  output logic        instrValid,
  output logic        misalignErr,
  output logic        timeoutErr
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0] retiredCount,
  output logic [31:0] stallCount
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(IMEM_TIMEOUT - 1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic        mis_q, mis_d;
  logic        to_q, to_d;
  logic [7:0]  cnt_q, cnt_d;
`ifdef PC_FETCH_PERF_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] stall_q, stall_d;
`endif

  // Next-state and datapath updates for the fetch sequencer
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
`ifdef PC_FETCH_PERF_EN
    retired_d = retired_q;
    stall_d   = stall_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imemAck) begin
          instr_d = imemRdata;
          valid_d = 1'b1;
          cnt_d   = 8'd0;
          state_d = READY;
        end else if (cnt_q == TIMEOUT_LAST) begin
          to_d    = 1'b1;
          state_d = HALT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      READY: begin
        if (pcWrite) begin
          valid_d = 1'b0;
          if (nextPc[1:0] == 2'b00) begin
            pc_d    = nextPc;
            state_d = FETCH;
`ifdef PC_FETCH_PERF_EN
            retired_d = sat_inc(retired_q);
`endif
          end else begin
            mis_d   = 1'b1;
            state_d = HALT;
          end
        end else begin
`ifdef PC_FETCH_PERF_EN
          stall_d = sat_inc(stall_q);
`endif
        end
      end
      HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    // Request is registered so it tracks the state being entered
    req_d = (state_d == FETCH);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= 8'd0;
`ifdef PC_FETCH_PERF_EN
      retired_q <= 32'd0;
      stall_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
`ifdef PC_FETCH_PERF_EN
      retired_q <= retired_d;
      stall_q   <= stall_d;
`endif
    end
  end

  assign imemReq     = req_q;
  assign imemAddr    = pc_q;
  assign pc          = pc_q;
  assign pcPlus4     = pc_q + 32'd4;
  assign instr       = instr_q;
  assign instrValid  = valid_q;
  assign misalignErr = mis_q;
  assign timeoutErr  = to_q;
`ifdef PC_FETCH_PERF_EN
  assign retiredCount = retired_q;
  assign stallCount   = stall_q;
`endif

endmodule
